imem_loader: RTL and testbench

- Program store and loader sitting directly upstream of `core`; it supplies `core.INSTR` for the PC that `core` presents.
- Accepts a program as a byte stream over a valid/ready handshake into a 128-entry instruction store, holding the core in reset while loading.
- After loading, releases the core and serves instructions combinationally from PC.
- Sanitises illegal opcodes to a NOP so the core only ever sees legal encodings.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_store.sv | 32 +++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types, sizes and opcode legality for the instruction store and loader.
//   ld_state_t     : loader FSM states (LOAD, RUN)
//   NOP_INSTR      : filler instruction (XORI #0)
//   is_legal_instr : opcode legality decode, also used by the core FV harness
package imem_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned LEN_W   = ADDR_W + 1;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h60;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } ld_state_t;

    // Legal: 00-07, 10-17, 20-27, 40-FF. Everything else below 40 is illegal.
    function automatic logic is_legal_instr(input logic [INSTR_W-1:0] instr);
        logic legal;
        if (instr[7:6] != 2'b00) begin
            legal = 1'b1;
        end else begin
            legal = (instr[3] == 1'b0) && (instr[5:4] != 2'b11);
        end
        return legal;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream loader handshake (valid/ready with end-of-program marker).
//   ld_valid : byte valid (master -> slave)
//   ld_data  : instruction byte (master -> slave)
//   ld_last  : final byte of program, qualified by ld_valid (master -> slave)
//   ld_ready : slave can accept a byte (slave -> master)
interface imem_loader_if;
    import imem_pkg::*;

    logic               ld_valid;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;
    logic               ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/imem_store.sv
// 128x8 flop-array instruction store: one synchronous write port, one
// combinational read port. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module imem_store
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Zero-latency read: the core samples the instruction in the same cycle it drives PC
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Program store and loader in front of the core. Loads a byte stream into
// the instruction store while holding the core in reset, then releases the
// core and serves instructions combinationally from its PC. Illegal opcodes
// are replaced by NOP on the way in and flagged on err_o.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   ld          : loader byte stream (slave side)
//   reload_i    : single-cycle restart request, honoured only in RUN
//   pc_i        : program counter from the core
//   instr_o     : instruction to the core (combinational from pc_i)
//   core_rstn_o : core reset, low while loading
//   len_o       : number of loaded instructions, 0..128
//   err_o       : sticky, an illegal byte was sanitised in the current load
module imem_loader
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    imem_loader_if.slave       ld,
    input  logic               reload_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               core_rstn_o,
    output logic [LEN_W-1:0]   len_o,
    output logic               err_o
);

    ld_state_t          state_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [ADDR_W-1:0]  waddr_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic               err_q;
    logic               core_rstn_q;
    logic               ld_ready_q;

    logic               xfer_c;
    logic               done_c;
    logic               legal_c;
    logic [INSTR_W-1:0] wdata_c;
    logic               in_range_c;
    logic [INSTR_W-1:0] rdata_c;

    // Transfer qualification, sanitising and counter increments
    always_comb begin
        xfer_c  = ld.ld_valid & ld_ready_q & ~rst_i;
        legal_c = is_legal_instr(ld.ld_data);
        wdata_c = legal_c ? ld.ld_data : NOP_INSTR;
        waddr_d = waddr_q + ADDR_W'(1);
        len_d   = len_q + LEN_W'(1);
        // The 128th byte ends the load even without ld_last, so len never exceeds DEPTH
        done_c  = ld.ld_last | (len_q == LEN_W'(DEPTH - 1));
    end

    // Loader FSM; ready and core reset are registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LOAD;
            waddr_q     <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            core_rstn_q <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer_c) begin
                        waddr_q <= waddr_d;
                        len_q   <= len_d;
                        if (!legal_c) begin
                            err_q <= 1'b1;
                        end
                        if (done_c) begin
                            state_q     <= RUN;
                            core_rstn_q <= 1'b1;
                            ld_ready_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (reload_i) begin
                        state_q     <= LOAD;
                        waddr_q     <= '0;
                        len_q       <= '0;
                        err_q       <= 1'b0;
                        core_rstn_q <= 1'b0;
                        ld_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    imem_store u_store (
        .clk_i   (clk_i),
        .we_i    (xfer_c),
        .waddr_i (waddr_q),
        .wdata_i (wdata_c),
        .raddr_i (pc_i),
        .rdata_o (rdata_c)
    );

    // Entries beyond len, and everything while loading, read as NOP
    always_comb begin
        in_range_c = {1'b0, pc_i} < len_q;
        instr_o    = ((state_q == RUN) && in_range_c) ? rdata_c : NOP_INSTR;
    end

    assign ld.ld_ready  = ld_ready_q;
    assign core_rstn_o  = core_rstn_q;
    assign len_o        = len_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_pkg::*;

    logic       clk;
    logic       rst;
    logic       reload;
    logic [6:0] pc;
    logic [7:0] instr;
    logic       core_rstn;
    logic [7:0] len;
    logic       err;

    imem_loader_if ld ();

    imem_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ld          (ld.slave),
        .reload_i    (reload),
        .pc_i        (pc),
        .instr_o     (instr),
        .core_rstn_o (core_rstn),
        .len_o       (len),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pc;
        logic [7:0] instr;
        logic [7:0] len;
        logic       err;
        logic       rstn;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic probe  = 1'b0;

    // Reference model: the loaded program as a queue of sanitised bytes
    logic [7:0] prog[$];
    bit         loaded   = 1'b0;
    bit         err_m    = 1'b0;
    bit         model_ok = 1'b0;

    function automatic bit ref_illegal(input logic [7:0] b);
        return (b >= 8'h08 && b <= 8'h0F) || (b >= 8'h18 && b <= 8'h1F) || (b >= 8'h28 && b <= 8'h3F);
    endfunction

    // One clock of stimulus: drive, record expectation for the current state, advance model
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic rl, input logic r, input logic [6:0] p);
        exp_t e;
        ld.ld_valid = v;
        ld.ld_data  = d;
        ld.ld_last  = l;
        reload      = rl;
        rst         = r;
        pc          = p;
        if (model_ok) begin
            e.pc    = p;
            e.instr = (loaded && int'(p) < prog.size()) ? prog[p] : 8'h60;
            e.len   = 8'(prog.size());
            e.err   = err_m;
            e.rstn  = loaded;
            e.rdy   = !loaded;
            exp_q.push_back(e);
            probe = 1'b1;
        end else begin
            probe = 1'b0;
        end
        if (r) begin
            prog.delete();
            loaded   = 1'b0;
            err_m    = 1'b0;
            model_ok = 1'b1;
        end else if (!loaded && v) begin
            prog.push_back(ref_illegal(d) ? 8'h60 : d);
            if (ref_illegal(d)) err_m = 1'b1;
            if (l || prog.size() == 128) loaded = 1'b1;
        end else if (loaded && rl) begin
            prog.delete();
            loaded = 1'b0;
            err_m  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'(i));
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want, input logic [6:0] p);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s pc=%0d got=%h want=%h t=%0t", name, p, act, want, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard head on every probed cycle
    always @(negedge clk) begin
        exp_t e;
        if (probe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got=empty want=entry t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("instr",     instr,              e.instr,          e.pc);
                chk("len",       len,                e.len,            e.pc);
                chk("err",       8'(err),            8'(e.err),        e.pc);
                chk("core_rstn", 8'(core_rstn),      8'(e.rstn),       e.pc);
                chk("ld_ready",  8'(ld.ld_ready),    8'(e.rdy),        e.pc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        ld.ld_valid = 1'b0;
        ld.ld_data  = 8'h00;
        ld.ld_last  = 1'b0;
        reload      = 1'b0;
        rst         = 1'b1;
        pc          = 7'd0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0);

        // Normal load and run
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 7'd1);
        step(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 7'd0);
        sweep(5);

        // Back-pressure gaps
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0);
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 7'd0);
        sweep(5);

        // Full program without last, then extra bytes must be refused
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 128; i++) step(1'b1, 8'(i) | 8'h80, 1'b0, 1'b0, 1'b0, 7'(i));
        for (int i = 0; i < 4; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 7'd127);
        sweep(128);

        // Illegal sanitise, reload attempt in LOAD is ignored
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0);
        step(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 7'd0);
        step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 7'd0);
        sweep(4);

        // Reload in RUN, then single-byte program
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 7'd1);
        sweep(3);

        // Reset mid-load
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0);
        step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 7'd0);
        sweep(3);

        // Randomised programs with gaps, illegal bytes, stray reloads and resets
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'($urandom));
            n = $urandom_range(1, 24);
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 2))
                    step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 7'($urandom_range(0, 31)));
                if ($urandom_range(0, 40) == 0)
                    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'd0);
                step(1'b1, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 63)) : 8'($urandom),
                     (b == n - 1) ? 1'b1 : 1'b0, 1'($urandom), 1'b0, 7'($urandom_range(0, 31)));
            end
            repeat (12)
                step(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 7'($urandom_range(0, 31)));
        end

        probe = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
